// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// No handshake: every signal is sampled and produced every cycle, with no valid/ready.
interface pipe_hazard_ctrl_if;
  logic [2:0]  Rs_ID;
  logic [2:0]  Rt_ID;
  logic        RsUsed_ID;
  logic        RtUsed_ID;
  logic        CtrlRd_ID;
  logic        Redirect_ID;
  logic [2:0]  RW_Ex;
  logic        RegWr_Ex;
  logic        MemRd_Ex;
  logic [2:0]  RW_Mem;
  logic        RegWr_Mem;
  logic        MemRd_Mem;
  logic [2:0]  RW_WB;
  logic        RegWr_WB;
  logic        PCWr;
  logic        IFIDWr;
  logic        IFIDFlush;
  logic        IDEXBubble;
  logic [1:0]  FwdA;
  logic [1:0]  FwdB;
  logic [15:0] StallCnt;
  logic [15:0] FlushCnt;
  logic [1:0]  Status;

  modport master (
    output Rs_ID, Rt_ID, RsUsed_ID, RtUsed_ID, CtrlRd_ID, Redirect_ID,
    output RW_Ex, RegWr_Ex, MemRd_Ex, RW_Mem, RegWr_Mem, MemRd_Mem,
    output RW_WB, RegWr_WB,
    input  PCWr, IFIDWr, IFIDFlush, IDEXBubble, FwdA, FwdB,
    input  StallCnt, FlushCnt, Status
  );

  modport slave (
    input  Rs_ID, Rt_ID, RsUsed_ID, RtUsed_ID, CtrlRd_ID, Redirect_ID,
    input  RW_Ex, RegWr_Ex, MemRd_Ex, RW_Mem, RegWr_Mem, MemRd_Mem,
    input  RW_WB, RegWr_WB,
    output PCWr, IFIDWr, IFIDFlush, IDEXBubble, FwdA, FwdB,
    output StallCnt, FlushCnt, Status
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for a 5-stage pipeline with 8 registers.
// Hazard outputs are combinational; the EX source copy, counters and Status are registered.
module pipe_hazard_ctrl (
  input  logic               CLK,
  input  logic               RST_N,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } status_e;

  logic [2:0]  rs_e_q, rs_e_d, rt_e_q, rt_e_d;
  logic        rs_used_e_q, rs_used_e_d, rt_used_e_q, rt_used_e_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  status_e     status_q, status_d;

  logic match_ex, match_mem, stall, flush;

  function automatic logic src_match(input logic wr, input logic [2:0] rw,
                                     input logic used, input logic [2:0] src);
    return wr && used && (rw == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic used, input logic [2:0] src,
                                         input logic wr_mem, input logic rd_mem,
                                         input logic [2:0] rw_mem, input logic wr_wb,
                                         input logic [2:0] rw_wb);
    if (used && wr_mem && !rd_mem && (rw_mem == src)) return 2'b01;
    else if (used && wr_wb && (rw_wb == src))        return 2'b10;
    else                                              return 2'b00;
  endfunction

  always_comb begin
    match_ex  = src_match(hz.RegWr_Ex, hz.RW_Ex, hz.RsUsed_ID, hz.Rs_ID) ||
                src_match(hz.RegWr_Ex, hz.RW_Ex, hz.RtUsed_ID, hz.Rt_ID);
    match_mem = src_match(hz.RegWr_Mem, hz.RW_Mem, hz.RsUsed_ID, hz.Rs_ID) ||
                src_match(hz.RegWr_Mem, hz.RW_Mem, hz.RtUsed_ID, hz.Rt_ID);
    // Gating with RST_N drops a pending stall the moment reset asserts.
    stall = RST_N && ((match_ex && hz.MemRd_Ex) ||
                      (hz.CtrlRd_ID && (match_ex || (match_mem && hz.MemRd_Mem))));
    flush = RST_N && !stall && hz.Redirect_ID;

    hz.PCWr       = !stall;
    hz.IFIDWr     = !stall;
    hz.IDEXBubble = stall;
    hz.IFIDFlush  = flush;
    hz.FwdA = fwd_sel(rs_used_e_q, rs_e_q, hz.RegWr_Mem, hz.MemRd_Mem, hz.RW_Mem,
                      hz.RegWr_WB, hz.RW_WB);
    hz.FwdB = fwd_sel(rt_used_e_q, rt_e_q, hz.RegWr_Mem, hz.MemRd_Mem, hz.RW_Mem,
                      hz.RegWr_WB, hz.RW_WB);
    hz.StallCnt = stall_cnt_q;
    hz.FlushCnt = flush_cnt_q;
    hz.Status   = status_q;
  end

  always_comb begin
    rs_e_d      = 3'd0;
    rt_e_d      = 3'd0;
    rs_used_e_d = 1'b0;
    rt_used_e_d = 1'b0;
    if (!stall) begin
      rs_e_d      = hz.Rs_ID;
      rt_e_d      = hz.Rt_ID;
      rs_used_e_d = hz.RsUsed_ID;
      rt_used_e_d = hz.RtUsed_ID;
    end
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (flush && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    status_d    = stall ? ST_STALL : (flush ? ST_FLUSH : ST_RUN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rs_e_q      <= 3'd0;
      rt_e_q      <= 3'd0;
      rs_used_e_q <= 1'b0;
      rt_used_e_q <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
      status_q    <= ST_RUN;
    end else begin
      rs_e_q      <= rs_e_d;
      rt_e_q      <= rt_e_d;
      rs_used_e_q <= rs_used_e_d;
      rt_used_e_q <= rt_used_e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      status_q    <= status_d;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK in 1, rising-edge clock shared with all pipeline stage buffers; RST_N in 1, asynchronous active-low reset.
REQ-002 The block SHALL have these decode-stage inputs: Rs_ID in 3; Rt_ID in 3; RsUsed_ID in 1; RtUsed_ID in 1, meaning the ID instruction reads Rs/Rt.
REQ-003 The block SHALL have input CtrlRd_ID in 1, asserted when the ID instruction consumes register values in ID (branch compare, For count test, indirect target).
REQ-004 The block SHALL have input Redirect_ID in 1, asserted when ID resolves a non-sequential PC (PCSrc!=0 or Loop).
REQ-005 The block SHALL have these execute-stage inputs: RW_Ex in 3; RegWr_Ex in 1; MemRd_Ex in 1.
REQ-006 The block SHALL have these memory-stage inputs: RW_Mem in 3; RegWr_Mem in 1; MemRd_Mem in 1.
REQ-007 The block SHALL have these write-back-stage inputs: RW_WB in 3; RegWr_WB in 1.
REQ-008 The block SHALL have these stall/flush outputs: PCWr out 1, PC update enable; IFIDWr out 1, IF/ID buffer load enable; IFIDFlush out 1, zero IF/ID at next edge; IDEXBubble out 1, insert NOP into ID/EX.
REQ-009 The block SHALL have outputs FwdA out 2 and FwdB out 2, the EX operand select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB BusW.
REQ-010 The block SHALL have these status outputs: StallCnt out 16, saturating stall-cycle count; FlushCnt out 16, saturating flush count; Status out 2, last-cycle action.

Function
REQ-011 Hazard outputs SHALL be combinational from current inputs and internal registers; all internal state SHALL update on rising CLK.
REQ-012 Matching rule: a producer (stage S) matches source X if RegWr_S=1, XUsed_ID=1 and RW_S==X_ID; all 8 registers, including R0, SHALL be treated alike.
REQ-013 Load-use: Stall=1 if a source matches EX with MemRd_Ex=1.
REQ-014 Control-read: with CtrlRd_ID=1, Stall=1 if a source matches EX (any producer) or MEM with MemRd_Mem=1; this yields 1 stall for an ALU producer in EX and 2 for a load in EX.
REQ-015 While Stall=1, the block SHALL drive PCWr=0, IFIDWr=0, IDEXBubble=1, IFIDFlush=0.
REQ-016 When Stall=0 and Redirect_ID=1, the block SHALL drive IFIDFlush=1, PCWr=1, IFIDWr=1, IDEXBubble=0; exactly one fetched slot is squashed.
REQ-017 Simultaneous stall and redirect: stall SHALL win; the redirect SHALL be honoured in the first non-stalled cycle because Redirect_ID is re-evaluated.
REQ-018 Otherwise the block SHALL drive PCWr=1, IFIDWr=1, IDEXBubble=0, IFIDFlush=0.
REQ-019 The block SHALL hold an internal EX-copy {RsE, RtE, RsUsedE, RtUsedE}; each edge, if Stall, it is cleared to zero, else it loads {Rs_ID, Rt_ID, RsUsed_ID, RtUsed_ID}.
REQ-020 FwdA: 01 if RsUsedE and RegWr_Mem and !MemRd_Mem and RW_Mem==RsE; else 10 if RsUsedE and RegWr_WB and RW_WB==RsE; else 00. MEM priority SHALL be over WB.
REQ-021 FwdB SHALL be identical to FwdA using RtUsedE/RtE.
REQ-022 StallCnt SHALL increment by 1 per cycle with Stall=1; FlushCnt SHALL increment by 1 per cycle with IFIDFlush=1; both SHALL saturate at 16'hFFFF and never wrap.
REQ-023 Status SHALL be a registered record of the previous cycle: 00 RUN, 01 STALL, 10 FLUSH, 11 unused and never produced.

Reset
REQ-024 While RST_N=0, the block SHALL asynchronously clear the EX-copy, StallCnt, FlushCnt and Status (to 00); with idle inputs, the outputs SHALL then be PCWr=1, IFIDWr=1, IFIDFlush=0, IDEXBubble=0, FwdA=FwdB=00.
REQ-025 Reset asserted mid-stall SHALL abandon the stall immediately with no residual bubble after release.
REQ-026 The first rising CLK after RST_N rises SHALL behave as a normal cycle.

Verification
REQ-027 Load r3 in EX (MemRd_Ex=1, RW_Ex=3); ID add reads Rs=3 -> one cycle PCWr=0/IDEXBubble=1, then FwdA=10 when the add is in EX; StallCnt=1.
REQ-028 ALU op writes r2 in MEM and another ALU op writes r2 in WB; EX consumer Rt=2 -> FwdB=01 (MEM priority).
REQ-029 Load r5 in EX; ID branch CtrlRd_ID=1 reads r5 -> exactly 2 stall cycles, then no stall; StallCnt=2.
REQ-030 Redirect_ID=1 coincident with a load-use stall -> 1 stall cycle, then IFIDFlush=1 for 1 cycle; FlushCnt=1; Status sequence 01,10,00.
REQ-031 StallCnt forced to 16'hFFFE, then 3 stall cycles -> StallCnt=16'hFFFF held.
REQ-032 RST_N pulsed low during the second cycle of a 2-cycle stall -> all counters 0, Status=00, PCWr=1 immediately.
